// File: rtl/femto_pkg.sv
// Shared constants and types for the femtoRV32 fetch path.
package femto_pkg;

  localparam logic [31:0] INST_NOP    = 32'h0000_0013;
  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  function automatic logic is_halt_inst(input logic [31:0] word);
    return (word == INST_ECALL) || (word == INST_EBREAK);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched {pc, inst} pairs; flush beats push.
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             pop_ok_s, push_ok_s;

  assign full      = (cnt_q == (PTR_W+1)'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign head      = mem_q[rd_q];
  assign pop_ok_s  = pop && !empty;
  assign push_ok_s = push && !flush && (!full || pop_ok_s);

  // Pointer and occupancy next-state
  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      rd_d  = rd_q + PTR_W'(pop_ok_s);
      wr_d  = wr_q + PTR_W'(push_ok_s);
      cnt_d = cnt_q + (PTR_W+1)'(push_ok_s) - (PTR_W+1)'(pop_ok_s);
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only visible while counted
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_q] <= wdata;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: PC, ROM addressing, redirect handling and
// ECALL/EBREAK halt, feeding decode through a small instruction queue.
module fetch_unit
  import femto_pkg::*;
#(
  parameter int          ADDR_W   = 6,
  parameter int          QDEPTH   = 2,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              inst_valid,
  output logic [31:0]       inst,
  output logic [31:0]       inst_pc,
  input  logic              inst_ready,
  output logic              halted
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         halted_q;
  logic         push_s, pop_s, full_s, empty_s;
  logic [63:0]  head_s;

  assign imem_addr  = pc_q[ADDR_W+1:2];
  assign pop_s      = !empty_s && inst_ready;
  assign push_s     = (state_q == RUN) && !redirect_valid && (!full_s || pop_s);
  assign inst_valid = !empty_s;
  assign inst       = empty_s ? INST_NOP : head_s[31:0];
  assign inst_pc    = empty_s ? 32'h0 : head_s[63:32];
  assign halted     = halted_q;

  fetch_queue #(
    .DEPTH (QDEPTH),
    .WIDTH (64)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .flush (redirect_valid),
    .wdata ({pc_q, imem_data}),
    .full  (full_s),
    .empty (empty_s),
    .head  (head_s)
  );

  // Redirect wins over halt detection; a halting word still advances the PC
  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    if (redirect_valid) begin
      pc_d    = redirect_pc & 32'hFFFF_FFFC;
      state_d = RUN;
    end else if (push_s) begin
      pc_d = pc_q + 32'd4;
      if (is_halt_inst(imem_data)) begin
        state_d = HALT;
      end else begin
        state_d = state_q;
      end
    end else begin
      pc_d    = pc_q;
      state_d = state_q;
    end
  end

  // FSM, PC and registered halt flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q     <= RESET_PC;
      state_q  <= RUN;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      state_q  <= state_d;
      halted_q <= (state_d == HALT);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a queue-based reference model.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [5:0]  imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        halted;

  logic [31:0] rom [64];
  logic [63:0] mq [$];
  logic [31:0] popped [$];
  logic [31:0] mpc;
  logic        mhalt;
  logic        started;
  int          errs;
  int          checks;

  fetch_unit #(.ADDR_W(6), .QDEPTH(2), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .halted         (halted)
  );

  assign imem_data = rom[imem_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a list of pending entries plus a PC and a halt flag
  initial begin
    logic [31:0] w;
    logic        pop;
    started = 1'b0;
    mpc     = 32'h0;
    mhalt   = 1'b0;
    forever begin
      @(posedge clk);
      started = 1'b1;
      if (!rst) begin
        mq.delete();
        mpc   = 32'h0;
        mhalt = 1'b0;
      end else begin
        pop = (mq.size() > 0) && inst_ready;
        if (pop) popped.push_back(mq[0][63:32]);
        if (redirect_valid) begin
          mq.delete();
          mpc   = redirect_pc & 32'hFFFF_FFFC;
          mhalt = 1'b0;
        end else begin
          if (pop) void'(mq.pop_front());
          if (!mhalt && mq.size() < 2) begin
            w = rom[mpc[7:2]];
            mq.push_back({mpc, w});
            mpc = mpc + 32'd4;
            if (w == 32'h0000_0073 || w == 32'h0010_0073) mhalt = 1'b1;
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        chk("m_valid", {31'd0, inst_valid}, {31'd0, mq.size() > 0});
        chk("m_halted", {31'd0, halted}, {31'd0, mhalt});
        chk("m_addr", {26'd0, imem_addr}, {26'd0, mpc[7:2]});
        if (mq.size() > 0) begin
          chk("m_inst", inst, mq[0][31:0]);
          chk("m_pc", inst_pc, mq[0][63:32]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, {31'd0, inst_valid}, 32'd0);
    chk({tag, "_inst"}, inst, 32'h0000_0013);
    chk({tag, "_pc"}, inst_pc, 32'd0);
    chk({tag, "_halted"}, {31'd0, halted}, 32'd0);
    chk({tag, "_addr"}, {26'd0, imem_addr}, 32'd0);
  endtask

  initial begin
    logic [31:0] exp_pc [6];
    logic [31:0] exp_in [6];
    logic [31:0] exp_log [5];
    errs = 0;
    checks = 0;
    for (int i = 0; i < 64; i++) rom[i] = 32'h0000_0013;
    rom[0] = 32'h0050_0093;
    rom[1] = 32'h0050_0113;
    rom[2] = 32'h0050_0193;
    rom[3] = 32'h0050_0213;
    rom[4] = 32'h0050_0293;
    rom[5] = 32'h0000_0073;
    rom[9] = 32'h0010_0073;
    exp_pc = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd16, 32'd20};
    exp_in = '{32'h0050_0093, 32'h0050_0113, 32'h0050_0193,
               32'h0050_0213, 32'h0050_0293, 32'h0000_0073};
    exp_log = '{32'd0, 32'd4, 32'd8, 32'd16, 32'd20};

    rst = 1'b0; inst_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    step(); step();
    chk_reset("por");

    // Streaming from reset up to the ECALL at word 5
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("stream_pc", inst_pc, exp_pc[i]);
      chk("stream_inst", inst, exp_in[i]);
    end
    chk("ecall_halted", {31'd0, halted}, 32'd1);
    chk("ecall_addr", {26'd0, imem_addr}, 32'd6);
    step();
    chk("drain_valid", {31'd0, inst_valid}, 32'd0);
    step();
    chk("halt_valid", {31'd0, inst_valid}, 32'd0);
    chk("halt_addr", {26'd0, imem_addr}, 32'd6);

    redirect_valid = 1'b1; redirect_pc = 32'h0;
    step();
    chk("resume_halted", {31'd0, halted}, 32'd0);
    chk("resume_bubble", {31'd0, inst_valid}, 32'd0);
    redirect_valid = 1'b0;
    step();
    chk("resume_pc", inst_pc, 32'd0);

    // Mid-stream reset, then back-pressure from the start
    rst = 1'b0;
    step();
    chk_reset("mid");
    rst = 1'b1; inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("full_addr", {26'd0, imem_addr}, 32'd2);
    chk("full_pc", inst_pc, 32'd0);
    chk("full_valid", {31'd0, inst_valid}, 32'd1);
    popped.delete();
    inst_ready = 1'b1;
    step();
    chk("rel_pc4", inst_pc, 32'd4);
    step();
    chk("rel_pc8", inst_pc, 32'd8);

    // Redirect to 16 while head is pc=8; pc=12 must never be delivered
    redirect_valid = 1'b1; redirect_pc = 32'd16;
    step();
    chk("redir_bubble", {31'd0, inst_valid}, 32'd0);
    redirect_valid = 1'b0;
    step();
    chk("redir_pc16", inst_pc, 32'd16);
    step();
    chk("redir_pc20", inst_pc, 32'd20);
    step();
    chk("log_size", popped.size(), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < popped.size()) chk("log_pc", popped[i], exp_log[i]);
    end

    // Redirect with pop while full, to a misaligned target
    inst_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0;
    step();
    redirect_valid = 1'b0;
    step(); step(); step();
    chk("full2_addr", {26'd0, imem_addr}, 32'd2);
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h13;
    step();
    chk("rp_empty", {31'd0, inst_valid}, 32'd0);
    chk("rp_addr", {26'd0, imem_addr}, 32'd4);
    redirect_valid = 1'b0;
    step();
    chk("rp_pc", inst_pc, 32'h10);
    chk("rp_inst", inst, 32'h0050_0293);
    step();
    chk("rp_pc2", inst_pc, 32'h14);

    // EBREAK at word 9
    redirect_valid = 1'b1; redirect_pc = 32'd32;
    step();
    redirect_valid = 1'b0;
    step(); step();
    chk("ebrk_pc", inst_pc, 32'd36);
    chk("ebrk_inst", inst, 32'h0010_0073);
    chk("ebrk_halted", {31'd0, halted}, 32'd1);
    step();
    chk("ebrk_valid", {31'd0, inst_valid}, 32'd0);
    chk("ebrk_addr", {26'd0, imem_addr}, 32'd10);

    // ROM address wraps past word 63
    redirect_valid = 1'b1; redirect_pc = 32'hFC;
    step();
    redirect_valid = 1'b0;
    step();
    chk("wrap_pc0", inst_pc, 32'hFC);
    step();
    chk("wrap_pc1", inst_pc, 32'h100);
    chk("wrap_inst", inst, 32'h0050_0093);
    chk("wrap_addr", {26'd0, imem_addr}, 32'd1);

    // Final mid-stream reset and restart
    rst = 1'b0;
    step();
    chk_reset("rst2");
    rst = 1'b1;
    step();
    chk("restart_pc", inst_pc, 32'd0);
    chk("restart_valid", {31'd0, inst_valid}, 32'd1);
    step();
    chk("restart_pc2", inst_pc, 32'd4);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
